fft_bitrev_reorder: RTL and testbench
=====================================

# fft_bitrev_reorder

Stream consumer sitting on the output side of `fft64_streaming`: it accepts the FFT's bit-reversed-order output frames (`real`/`imag`/`valid`/`last` stream) and re-emits each frame in natural bin order. It uses a two-bank ping-pong buffer, so one frame fills while the previous one drains. The downstream side has a ready/valid handshake. Sustained throughput is one sample per cycle when the downstream is always ready.

## Interface
- `DATA_W`, default 20: width of each real/imag component; matches the FFT output width `DATA_W+GROWTH`.
- `POINTS`, default 64: frame length. Must be a power of two, ≥4. `LOG2P = $clog2(POINTS)`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `real_in`, `imag_in`  in  DATA_W each: signed sample from the FFT.
- `valid_in`  in  1: sample present. There is no backpressure to the FFT.
- `last_in`  in  1: marks the final sample of a frame.
- `out_ready`  in  1: downstream accepts the current output sample.
- `real_out`, `imag_out`  out  DATA_W each: signed natural-order sample. Forced to 0 whenever `valid_out`=0.
- `valid_out`  out  1: output sample present.
- `last_out`  out  1: high with the bin `POINTS-1` output sample.
- `done`  out  1: one-cycle pulse on the edge that consumes the last sample of a frame.
- `overflow`  out  1: one-cycle pulse when a frame is dropped because there is no free bank.
- `frame_err`  out  1: one-cycle pulse when a frame is discarded for a length/`last_in` mismatch.

## Operation
- **Storage**
  - Two banks of `POINTS` entries, each entry `2*DATA_W` bits.
  - Per-bank `full` flag.
  - Write state: `wr_bank`, `wr_idx` (LOG2P bits), `drop` flag.
  - Read state: `rd_bank`, `rd_idx`.
- **Write side.** Each sample is accepted when `valid_in`=1.
  - The sample at position k of a frame goes to `bank[wr_bank][bitrev(k)]`. `bitrev` reverses all LOG2P bits.
  - `wr_idx` increments after each write.
- **Frame commit.** When `wr_idx`=`POINTS-1` and `last_in`=1:
  - `full[wr_bank]`←1, `wr_bank` toggles, `wr_idx`←0.
- **Length errors.** In both cases below: pulse `frame_err`, set `wr_idx`←0, do not set `full`, keep `wr_bank` (the partial data is overwritten later).
  - `last_in`=1 with `wr_idx`≠`POINTS-1`.
  - `wr_idx`=`POINTS-1` with `last_in`=0.
- **Overflow.** When a sample arrives with `wr_idx`=0, `drop`=0 and `full[wr_bank]`=1:
  - Pulse `overflow`, set `drop`←1, write nothing.
  - While `drop`=1, every sample is discarded and `wr_idx` stays 0.
  - The sample with `last_in`=1 clears `drop`; that sample is also discarded.
  - `frame_err` is not raised for dropped frames.
  - The `full` check uses the flag value before the edge. A bank being cleared on the same edge still counts as full.
- **Read side.**
  - `valid_out` = `full[rd_bank]`.
  - Output data = `bank[rd_bank][rd_idx]`, read combinationally from the register array.
  - On `valid_out && out_ready`: `rd_idx` increments.
  - On the sample where `rd_idx`=`POINTS-1`: `full[rd_bank]`←0, `rd_bank` toggles, `rd_idx`←0, `done` pulses.
  - `last_out` = `valid_out && rd_idx==POINTS-1`.
- **Handshake.** While `valid_out && !out_ready`, the data, `valid_out` and `last_out` are held stable.
- **Independence.** Write and read sides operate on different banks. A commit and a drain completing on the same edge are both honoured.
- **Arithmetic.** None; samples pass through bit-exact.

## Timing
- **Reset (async, `rst_n`=0).** Immediately clears:
  - `full`=00, `wr_bank`=`rd_bank`=0, `wr_idx`=`rd_idx`=0, `drop`=0.
  - All outputs become 0.
  - Memory is not cleared, but it is invisible because no bank is full.
  - Reset mid-frame loses all buffered and partial frames. The first post-reset sample is position 0 of a new frame.
- **Latency.** Frame committed on edge N → `valid_out`=1 from edge N onward, presenting bin 0. Input-to-output latency is therefore `POINTS` cycles.
- **Throughput.** With `out_ready` held at 1, back-to-back input frames produce back-to-back output frames with zero idle cycles. A bank is freed on the same edge the other bank commits.
- **Pulses.** `done`, `overflow` and `frame_err` are registered pulses, high for the cycle after the triggering edge.

## Test plan
- **Ramp frame.** Input k=0..63 with `real`=k, `imag`=−k, `last_in` at k=63, `out_ready`=1 → outputs `real`=0,32,16,48,8,40,… (bitrev(n)), `imag` negated. `last_out` is high with `real`=63, followed by a `done` pulse. First `valid_out` occurs right after the commit edge.
- **Two frames back-to-back.** Ramp then ramp+100, with `out_ready`=1 → 128 consecutive valid outputs with no gap. The second frame's first output is `real`=100.
- **Backpressure.** Toggle `out_ready` 1-0-0-1 randomly → every output stalls while not ready, with the same values held. The full 64-sample sequence is unchanged; `done` fires once.
- **Overflow.** `out_ready`=0, then send 3 complete frames → frames 1 and 2 are stored. At frame 3's first sample, `overflow` pulses once. Releasing `out_ready` yields only frames 1 and 2.
- **Short frame.** 10 samples with `last_in` on the 10th, then a valid ramp frame → `frame_err` pulses once. Output is only the ramp frame, correctly ordered.
- **Reset mid-drain.** Assert `rst_n`=0 after 20 outputs → `valid_out`, `last_out` and data drop to 0 immediately. A new frame after reset is output correctly, starting at bin 0.

Source files
------------

// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle between the FFT output, the bit-reverse reorder buffer and its downstream consumer.
interface fft_bitrev_reorder_if #(
  parameter int DATA_W = 20
);
  logic signed [DATA_W-1:0] real_in;
  logic signed [DATA_W-1:0] imag_in;
  logic                     valid_in;
  logic                     last_in;
  logic                     out_ready;
  logic signed [DATA_W-1:0] real_out;
  logic signed [DATA_W-1:0] imag_out;
  logic                     valid_out;
  logic                     last_out;
  logic                     done;
  logic                     overflow;
  logic                     frame_err;

  modport master (
    output real_in, imag_in, valid_in, last_in, out_ready,
    input  real_out, imag_out, valid_out, last_out, done, overflow, frame_err
  );

  modport slave (
    input  real_in, imag_in, valid_in, last_in, out_ready,
    output real_out, imag_out, valid_out, last_out, done, overflow, frame_err
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong buffer turning bit-reversed FFT output frames into natural bin order
// with a ready/valid downstream side.
module fft_bitrev_reorder #(
  parameter int DATA_W = 20,
  parameter int POINTS = 64
) (
  input logic               clk,
  input logic               rst_n,
  fft_bitrev_reorder_if.slave bus
);
  localparam int LOG2P = $clog2(POINTS);
  localparam logic [LOG2P-1:0] LAST_IDX = LOG2P'(POINTS - 1);

  logic [2*DATA_W-1:0] mem_q [2][POINTS];

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic [LOG2P-1:0] wr_idx_q, wr_idx_d;
  logic             drop_q, drop_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2P-1:0] rd_idx_q, rd_idx_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;
  logic             we;
  logic             valid_out_w;
  logic [2*DATA_W-1:0] rd_word;

  function automatic logic [LOG2P-1:0] bitrev(input logic [LOG2P-1:0] v);
    logic [LOG2P-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2P; i++) r[i] = v[LOG2P-1-i];
    return r;
  endfunction

  assign valid_out_w = full_q[rd_bank_q];
  assign rd_word     = mem_q[rd_bank_q][rd_idx_q];

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    drop_d    = drop_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    done_d    = 1'b0;
    ovf_d     = 1'b0;
    ferr_d    = 1'b0;
    we        = 1'b0;

    // Drain side: clear before set so a same-edge commit on the other bank survives.
    if (valid_out_w && bus.out_ready) begin
      if (rd_idx_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_idx_d          = '0;
        done_d            = 1'b1;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end

    if (bus.valid_in) begin
      if (drop_q) begin
        if (bus.last_in) drop_d = 1'b0;
      end else if (wr_idx_q == '0 && full_q[wr_bank_q]) begin
        ovf_d  = 1'b1;
        drop_d = ~bus.last_in;
      end else begin
        we = 1'b1;
        if (bus.last_in && wr_idx_q == LAST_IDX) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
          wr_idx_d          = '0;
        end else if (bus.last_in || wr_idx_q == LAST_IDX) begin
          ferr_d   = 1'b1;
          wr_idx_d = '0;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      drop_q    <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      drop_q    <= drop_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
    end
  end

  // Sample storage is never reset; contents are only visible through a full bank.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_bank_q][bitrev(wr_idx_q)] <= {bus.real_in, bus.imag_in};
  end

  assign bus.valid_out = valid_out_w;
  assign bus.last_out  = valid_out_w && (rd_idx_q == LAST_IDX);
  assign bus.real_out  = valid_out_w ? rd_word[2*DATA_W-1:DATA_W] : '0;
  assign bus.imag_out  = valid_out_w ? rd_word[DATA_W-1:0] : '0;
  assign bus.done      = done_q;
  assign bus.overflow  = ovf_q;
  assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for the bit-reverse reorder buffer: expected natural-order samples
// are queued as frames are sent and popped as the DUT hands them downstream.
module tb_fft_bitrev_reorder;
  localparam int DW    = 20;
  localparam int P     = 64;
  localparam int LOG2P = $clog2(P);
  localparam int W     = 2*DW + 1;

  logic clk;
  logic rst_n;

  fft_bitrev_reorder_if #(.DATA_W(DW)) bif ();

  fft_bitrev_reorder #(.DATA_W(DW), .POINTS(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  logic [W-1:0] q[$];
  int pops, done_cnt, ovf_cnt, ferr_cnt;
  int cyc, mark_pops, mark_cyc, last_fire_cyc;
  bit rnd_ready;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int tb_bitrev(input int v);
    int r;
    r = 0;
    for (int i = 0; i < LOG2P; i++) r |= ((v >> i) & 1) << (LOG2P - 1 - i);
    return r;
  endfunction

  // Output bin n carries input position bitrev(n); ramp input k holds base+k / -(base+k).
  task automatic push_frame(input int base);
    logic [DW-1:0] r;
    logic [DW-1:0] im;
    for (int n = 0; n < P; n++) begin
      r  = DW'(base + tb_bitrev(n));
      im = DW'(-(base + tb_bitrev(n)));
      q.push_back({r, im, (n == P-1)});
    end
  endtask

  task automatic send_frame(input int base, input int len);
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      bif.valid_in = 1'b1;
      bif.real_in  = DW'(base + k);
      bif.imag_in  = DW'(-(base + k));
      bif.last_in  = (k == len-1);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bif.valid_in = 1'b0;
    bif.last_in  = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1;
    rnd_ready     = 1'b0;
    bif.out_ready = r;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int d0, o0, f0, p0;
    logic [W-1:0] exp_w;
    logic [W:0]   hold_val;
    bit           hold_pend;

    n_cmp = 0; n_err = 0; pops = 0; done_cnt = 0; ovf_cnt = 0; ferr_cnt = 0;
    cyc = 0; mark_pops = -1; mark_cyc = 0; last_fire_cyc = 0;
    rnd_ready = 1'b0; hold_pend = 1'b0; hold_val = '0;
    rst_n = 1'b0;
    bif.valid_in = 1'b0; bif.last_in = 1'b0;
    bif.real_in = '0; bif.imag_in = '0; bif.out_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (rst_n) begin
          if (hold_pend)
            chk("hold", {bif.valid_out, bif.real_out, bif.imag_out, bif.last_out}, hold_val);
          hold_pend = bif.valid_out && !bif.out_ready;
          hold_val  = {bif.valid_out, bif.real_out, bif.imag_out, bif.last_out};
          if (!bif.valid_out) begin
            chk("idle_zero", {bif.real_out, bif.imag_out, bif.last_out}, '0);
          end else if (bif.out_ready) begin
            if (q.size() == 0) begin
              chk("unexpected_out", bif.valid_out, 0);
            end else begin
              exp_w = q.pop_front();
              chk("data", {bif.real_out, bif.imag_out, bif.last_out}, exp_w);
              if (pops == mark_pops) mark_cyc = cyc;
              pops++;
              last_fire_cyc = cyc;
            end
          end
          if (bif.done)      done_cnt++;
          if (bif.overflow)  ovf_cnt++;
          if (bif.frame_err) ferr_cnt++;
        end else begin
          hold_pend = 1'b0;
        end
      end
      forever begin
        @(posedge clk); #1;
        if (rnd_ready) bif.out_ready = 1'($urandom_range(0, 1));
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_state", {bif.valid_out, bif.last_out, bif.done, bif.overflow, bif.frame_err,
                      bif.real_out, bif.imag_out}, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Ramp frame: first valid right after the commit edge, done once
    d0 = done_cnt;
    push_frame(0);
    send_frame(0, P);
    idle();
    @(negedge clk);
    chk("latency_valid", bif.valid_out, 1);
    wait_drain(400);
    chk("ramp_done", done_cnt - d0, 1);

    // Two frames back-to-back with no output gap
    d0 = done_cnt;
    mark_pops = pops;
    push_frame(0);
    push_frame(100);
    send_frame(0, P);
    send_frame(100, P);
    idle();
    wait_drain(600);
    chk("b2b_span", last_fire_cyc - mark_cyc + 1, 2*P);
    chk("b2b_done", done_cnt - d0, 2);

    // Random backpressure
    d0 = done_cnt;
    @(posedge clk); #1 rnd_ready = 1'b1;
    push_frame(200);
    send_frame(200, P);
    idle();
    wait_drain(2000);
    set_ready(1'b1);
    chk("bp_done", done_cnt - d0, 1);

    // Overflow: third frame finds no free bank
    d0 = done_cnt; o0 = ovf_cnt; f0 = ferr_cnt;
    set_ready(1'b0);
    push_frame(1000);
    push_frame(2000);
    send_frame(1000, P);
    send_frame(2000, P);
    send_frame(3000, P);
    idle();
    repeat (4) @(negedge clk);
    chk("ovf_pulse", ovf_cnt - o0, 1);
    chk("ovf_no_ferr", ferr_cnt - f0, 0);
    chk("ovf_stalled", bif.valid_out, 1);
    set_ready(1'b1);
    wait_drain(600);
    chk("ovf_done", done_cnt - d0, 2);

    // Short frame discarded, following ramp intact
    d0 = done_cnt; f0 = ferr_cnt; o0 = ovf_cnt;
    send_frame(50, 10);
    push_frame(300);
    send_frame(300, P);
    idle();
    wait_drain(400);
    chk("short_ferr", ferr_cnt - f0, 1);
    chk("short_done", done_cnt - d0, 1);
    chk("short_no_ovf", ovf_cnt - o0, 0);

    // Reset mid-drain
    p0 = pops;
    push_frame(500);
    send_frame(500, P);
    idle();
    for (int i = 0; i < 400; i++) begin
      if (pops >= p0 + 20) break;
      @(negedge clk);
    end
    chk("rst_wait", pops - p0 >= 20, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out", {bif.valid_out, bif.last_out, bif.real_out, bif.imag_out}, '0);
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    d0 = done_cnt;
    push_frame(700);
    send_frame(700, P);
    idle();
    wait_drain(400);
    chk("post_rst_done", done_cnt - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
